// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART framing defaults and receiver FSM state encoding.
// The sender imports the same defaults so both ends agree on the framing.
package uart_rx_fifo_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
    localparam int unsigned DEFAULT_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with count and full/empty flags.
// A pop on a full FIFO frees a slot for a push in the same cycle.
// A pop on an empty FIFO is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Resolve effective push/pop and compute the next pointers and count.
    always_comb begin
        do_pop  = i_pop && (count_q != '0);
        do_push = i_push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are only meaningful where count says so.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= i_wdata;
        end
    end

    assign o_count = count_q;
    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_rdata = o_empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver that deframes the serial line into bytes
// and buffers them in a show-ahead FIFO, with sticky overflow/framing flags.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_data,
    input  logic                   i_rd_en,
    input  logic                   i_clr_err,
    output logic [DATA_BITS-1:0]   o_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow,
    output logic                   o_frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 sync1_q, sync2_q;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 overflow_q, overflow_d;
    logic                 frame_err_q, frame_err_d;
    logic                 cnt_at_max, push, frame_set, fifo_full;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_data;
            sync2_q <= sync1_q;
        end
    end

    // Deframing FSM next state: counter, bit index, shift register, push/error strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        push       = 1'b0;
        frame_set  = 1'b0;
        cnt_at_max = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        cnt_inc    = cnt_at_max ? '0 : cnt_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (!sync2_q) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
                    // Line back high at mid-start-bit is a glitch, not a frame.
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = sync2_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StData: begin
                cnt_d = cnt_inc;
                if (cnt_at_max) begin
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StStop: begin
                cnt_d = cnt_inc;
                if (cnt_at_max) begin
                    if (sync2_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = StBreak;
                    end
                end
            end
            StBreak: begin
                // Hold here until the line releases so a long break counts once.
                cnt_d = '0;
                if (sync2_q) state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
    always_comb begin
        overflow_d  = (overflow_q & ~i_clr_err) | (push & fifo_full & ~i_rd_en);
        frame_err_d = (frame_err_q & ~i_clr_err) | frame_set;
    end

    // FSM and flag registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (push),
        .i_pop  (i_rd_en),
        .i_wdata(shift_q),
        .o_rdata(o_data),
        .o_count(o_count),
        .o_empty(o_empty),
        .o_full (fifo_full)
    );

    assign o_full      = fifo_full;
    assign o_overflow  = overflow_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (CLKS_PER_BIT=16, DATA_BITS=8, DEPTH=8).
// Stimulus tasks start and end 1 time unit after a rising clock edge.
module tb_uart_rx_fifo;

    localparam int CPB = 16;
    // Edges from the start-bit fall to the push: 2 sync + half bit + 9 full bits.
    localparam int PUSH_EDGE = 2 + CPB / 2 + CPB * 9;

    logic       clk, rst, din, rd_en, clr_err;
    logic [7:0] dout;
    logic       empty, full, ovf, ferr;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] din;
        logic [3:0] cnt;
        logic       full;
        logic       ovf;
        logic [7:0] head;
    } vec_t;

    vec_t tbl [9];

    uart_rx_fifo #(
        .CLKS_PER_BIT(16),
        .DATA_BITS   (8),
        .DEPTH       (8)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_data     (din),
        .i_rd_en    (rd_en),
        .i_clr_err  (clr_err),
        .o_data     (dout),
        .o_empty    (empty),
        .o_full     (full),
        .o_count    (count),
        .o_overflow (ovf),
        .o_frame_err(ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_v, stop_len);
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_data"}, dout, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_ferr"}, ferr, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{din: 8'(i + 1), cnt: 4'(i + 1), full: (i == 7), ovf: 1'b0, head: 8'h01};
        end
        tbl[8] = '{din: 8'hFF, cnt: 4'd8, full: 1'b1, ovf: 1'b1, head: 8'h01};

        rst = 1'b1; din = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        hold(1'b1, 4);

        // Single frame: exact push latency from the start-bit fall.
        fork
            send_frame(8'hA5, 1'b1, CPB);
            begin
                repeat (PUSH_EDGE) @(posedge clk);
                #1;
                chk("a5_empty_before_push", empty, 1);
                @(posedge clk);
                #1;
                chk("a5_empty_after_push", empty, 0);
                chk("a5_data", dout, 8'hA5);
                chk("a5_count", count, 1);
            end
        join
        pulse_rd();
        chk("a5_popped_empty", empty, 1);

        // Fill to full and overflow with a ninth frame.
        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].din, 1'b1, CPB);
            chk($sformatf("fill%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("fill%0d_full", i), full, tbl[i].full);
            chk($sformatf("fill%0d_ovf", i), ovf, tbl[i].ovf);
            chk($sformatf("fill%0d_head", i), dout, tbl[i].head);
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_head", i), dout, tbl[i].din);
            pulse_rd();
        end
        chk("drain_empty", empty, 1);
        chk("drain_data_zero", dout, 0);
        pulse_clr();
        chk("ovf_cleared", ovf, 0);
        pulse_rd();
        chk("pop_empty_count", count, 0);
        chk("pop_empty_ovf", ovf, 0);
        chk("pop_empty_empty", empty, 1);

        // Short low glitch is rejected.
        hold(1'b0, 6);
        hold(1'b1, 40);
        chk("glitch_count", count, 0);
        chk("glitch_ferr", ferr, 0);
        chk("glitch_ovf", ovf, 0);

        // Stop bit held low: one framing error, then normal reception.
        send_frame(8'h3C, 1'b0, 40);
        hold(1'b1, CPB);
        chk("break_ferr", ferr, 1);
        chk("break_count", count, 0);
        pulse_clr();
        hold(1'b1, 200);
        chk("break_single_err", ferr, 0);
        chk("break_no_push", count, 0);
        send_frame(8'h55, 1'b1, CPB);
        chk("post_break_count", count, 1);
        chk("post_break_data", dout, 8'h55);
        pulse_rd();

        // Full FIFO with a pop in the stop-sample cycle.
        for (int i = 0; i < 8; i++) send_frame(8'(8'h11 + i), 1'b1, CPB);
        chk("pp_full_before", full, 1);
        fork
            send_frame(8'h99, 1'b1, CPB);
            begin
                repeat (PUSH_EDGE) @(posedge clk);
                #1;
                rd_en = 1'b1;
                @(posedge clk);
                #1;
                rd_en = 1'b0;
                chk("pp_count", count, 8);
                chk("pp_ovf", ovf, 0);
                chk("pp_full", full, 1);
                chk("pp_head", dout, 8'h12);
            end
        join
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("pp_drain%0d", i), dout, 8'(8'h12 + i));
            pulse_rd();
        end
        chk("pp_last", dout, 8'h99);
        pulse_rd();
        chk("pp_empty", empty, 1);

        // Mid-frame asynchronous reset with stored bytes and a flag set.
        send_frame(8'h00, 1'b0, CPB);
        hold(1'b1, CPB);
        chk("pre_rst_ferr", ferr, 1);
        send_frame(8'hA1, 1'b1, CPB);
        send_frame(8'hB2, 1'b1, CPB);
        chk("pre_rst_count", count, 2);
        fork
            send_frame(8'h77, 1'b1, CPB);
            begin
                repeat (60) @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                check_reset_outputs("async_rst");
            end
        join
        rst = 1'b0;
        hold(1'b1, 4);
        chk("post_rst_no_partial", count, 0);
        send_frame(8'h12, 1'b1, CPB);
        chk("post_rst_count", count, 1);
        chk("post_rst_data", dout, 8'h12);

        // Clear in the same cycle as a new overflow: set wins.
        for (int i = 0; i < 7; i++) send_frame(8'(8'h21 + i), 1'b1, CPB);
        chk("clr_full", full, 1);
        fork
            send_frame(8'hEE, 1'b1, CPB);
            begin
                repeat (PUSH_EDGE) @(posedge clk);
                #1;
                clr_err = 1'b1;
                @(posedge clk);
                #1;
                clr_err = 1'b0;
                chk("clr_vs_set_ovf", ovf, 1);
                chk("clr_vs_set_count", count, 8);
                chk("clr_vs_set_head", dout, 8'h12);
            end
        join
        pulse_clr();
        chk("final_ovf_cleared", ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
